register_file_sb: RTL
=====================

Name: register_file_sb

Overview:
Parametrised successor to the two-port CPU register file. It provides NUM_RD combinational read ports and one write port. Register 0 is hardwired to zero, and an optional same-cycle write-to-read bypass is selectable. An integrated pending-write scoreboard tracks destination registers of long-latency operations (loads, multiply/divide) so decode can detect RAW hazards. Sits between decode (read/reserve) and writeback (write/release) in the core pipeline.

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers (power of two, >=2)
IDX_W, $clog2(NUM_REGS), register index width (derived; do not override)
NUM_RD, 2, number of read ports (1..4)
BYPASS, 1, 1 = write data forwarded to same-cycle reads of the same index; 0 = reads return the old value

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
reg_write  in  1  write enable for the writeback port
write_index  in  IDX_W  destination register
write_data  in  DATA_W  data to write
read_index  in  NUM_RD*IDX_W  packed read indices; port p = bits [p*IDX_W +: IDX_W]
read_data  out  NUM_RD*DATA_W  packed read data, combinational
read_busy  out  NUM_RD  1 = port p's register has a pending write (RAW hazard)
reserve_en  in  1  mark reserve_index as pending (long-latency op issued)
reserve_index  in  IDX_W  register to reserve
flush  in  1  clear all pending bits (pipeline flush)
pending_cnt  out  IDX_W+1  number of registers currently marked pending

Behaviour:
- Storage: NUM_REGS x DATA_W array plus NUM_REGS-bit busy vector. Entry 0 is not stored; reads of index 0 return 0, and busy[0] is constant 0.
- Reset (rst=1 at a clock edge): all registers <= 0, busy <= 0, pending_cnt <= 0. From the following cycle, read_data = 0 and read_busy = 0 for every index. A reset mid-operation discards all pending reservations; writes or reserves in the reset cycle are ignored.
- Write: if reg_write && write_index != 0, then regs[write_index] <= write_data at the edge. Writes to index 0 are dropped.
- Read, combinational, per port p:
  - index == 0 -> 0.
  - BYPASS=1 && reg_write && write_index == index != 0 -> write_data.
  - Otherwise -> the stored value.
- read_busy[p] = busy[index], except forced to 0 when BYPASS=1 and a bypassing write to that index is present in the same cycle.
- Scoreboard update at each edge, priority high to low:
  1. rst: all busy bits cleared.
  2. flush: all busy bits cleared; the same-cycle reserve and the write-driven clear are ignored. The data write itself still occurs.
  3. Otherwise:
     - reg_write && write_index != 0 clears busy[write_index].
     - reserve_en && reserve_index != 0 sets busy[reserve_index].
     - Reserve and write to the same index in the same cycle: set wins, busy stays 1. The new op is younger than the completing one.
  - Reserving an already-busy index keeps it at 1; there is no counting per register.
  - A write to a non-busy register is legal and only updates data.
- pending_cnt: registered population count of busy[NUM_REGS-1:1], equal to the count after the update. Range 0..NUM_REGS-1.
- Latency: read 0 cycles (combinational). Write is visible to non-bypassed reads on the next cycle. Reserve is visible on read_busy on the next cycle.
- Multiple read ports may address the same index; each returns identical data and busy.

Test Plan:
- Reset then read: rst=1 for 1 cycle, then read_index = {5,0} -> read_data = {0,0}, read_busy = 0, pending_cnt = 0.
- Write then read: write x5 = 0xDEADBEEF; next cycle read x5 on both ports -> 0xDEADBEEF on both. Write x0 = 0x1234 -> a read of x0 returns 0.
- Bypass, same cycle: reg_write x7 = 0xA5A5A5A5 while reading x7 -> BYPASS=1 returns 0xA5A5A5A5 and busy 0; BYPASS=0 returns the old value.
- Scoreboard set/clear: reserve x3 -> next cycle read_busy = 1 and pending_cnt = 1. Write x3 -> busy = 0 and pending_cnt = 0. Reserve x3 and write x3 in the same cycle -> busy remains 1.
- Flush priority: reserve x4 and x9 over 2 cycles (pending_cnt = 2). Then flush=1 with reserve x10 -> next cycle all busy = 0 and pending_cnt = 0.
- Reserve x0 or write x0 -> busy[0] stays 0, pending_cnt unchanged. Assert rst mid-run with 3 pending -> all cleared, data 0.

Source files
------------

// File: rtl/register_file_sb.sv
// register_file_sb -- parametrised CPU register file with a pending-write
// scoreboard.
//
// The file has NUM_RD combinational read ports and one write port. Register 0
// always reads as zero and can never be marked busy. When BYPASS=1, a write
// that is in flight in the current cycle is forwarded to reads of the same
// index. The busy vector is set by decode when it issues a long-latency op
// (reserve) and cleared by writeback when the result lands (write).
//
// Ports:
//   clk           core clock; all state changes on the rising edge
//   rst           synchronous, active-high reset (data, busy and count to 0)
//   reg_write     write enable for the writeback port
//   write_index   destination register of the write
//   write_data    data to write
//   read_index    packed read indices; port p = [p*IDX_W +: IDX_W]
//   read_data     packed read data; port p = [p*DATA_W +: DATA_W]
//   read_busy     per-port RAW-hazard flag (register has a pending write)
//   reserve_en    mark reserve_index as pending
//   reserve_index register to reserve
//   flush         clear every pending bit (the data write still happens)
//   pending_cnt   number of registers currently pending (registered)
module register_file_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reg_write,
  input  logic [IDX_W-1:0]         write_index,
  input  logic [DATA_W-1:0]        write_data,
  input  logic [NUM_RD*IDX_W-1:0]  read_index,
  output logic [NUM_RD*DATA_W-1:0] read_data,
  output logic [NUM_RD-1:0]        read_busy,
  input  logic                     reserve_en,
  input  logic [IDX_W-1:0]         reserve_index,
  input  logic                     flush,
  output logic [IDX_W:0]           pending_cnt
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [IDX_W:0]      cnt_q;
  logic [IDX_W:0]      cnt_d;

  // Writes and reserves aimed at register 0 are discarded everywhere.
  logic wr_en;
  logic rsv_en;
  assign wr_en  = reg_write  && (write_index   != '0);
  assign rsv_en = reserve_en && (reserve_index != '0);

  // Scoreboard next state. Within the non-flush case the set is applied after
  // the clear, so a reserve and a completing write to the same register leave
  // it busy: the reserving op is younger than the one writing back.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_en)  busy_d[write_index]   = 1'b0;
      if (rsv_en) busy_d[reserve_index] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // The count is registered from the post-update vector so it always matches
  // busy_q in the same cycle.
  always_comb begin
    cnt_d = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      cnt_d = cnt_d + {{IDX_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) regs_q[write_index] <= write_data;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_cnt = cnt_q;

  // Read ports. A forwarded write also hides the busy bit, because the value
  // the reader receives is exactly the one that would clear it.
  logic [IDX_W-1:0] rd_idx;
  always_comb begin
    read_data = '0;
    read_busy = '0;
    rd_idx    = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_idx = read_index[p*IDX_W +: IDX_W];
      if (rd_idx == '0) begin
        read_data[p*DATA_W +: DATA_W] = '0;
        read_busy[p]                  = 1'b0;
      end else if ((BYPASS != 0) && wr_en && (write_index == rd_idx)) begin
        read_data[p*DATA_W +: DATA_W] = write_data;
        read_busy[p]                  = 1'b0;
      end else begin
        read_data[p*DATA_W +: DATA_W] = regs_q[rd_idx];
        read_busy[p]                  = busy_q[rd_idx];
      end
    end
  end

endmodule
